// File: rtl/stk_ram_pkg.sv
// Shared types and helpers for the StkRamIf memory responder.
//  stk_ram_st_e : responder FSM states (memory clear, normal service)
//  lane_merge   : overlays strobed lanes of a new word onto an old word
package stk_ram_pkg;

   typedef enum logic [0:0] {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } stk_ram_st_e;

   // Upper bounds for the generic merge helper; callers zero-extend into these widths.
   localparam int unsigned LM_MAX_DW  = 256;
   localparam int unsigned LM_MAX_STB = 32;

   // Per-lane overlay: lane i of new_w replaces lane i of old_w when strb[i] is set.
   function automatic logic [LM_MAX_DW-1:0] lane_merge(
      input logic [LM_MAX_DW-1:0]  old_w,
      input logic [LM_MAX_DW-1:0]  new_w,
      input logic [LM_MAX_STB-1:0] strb,
      input int unsigned           stb_n,
      input int unsigned           lw
   );
      logic [LM_MAX_DW-1:0] mask;
      logic [LM_MAX_DW-1:0] lane_ones;
      mask      = '0;
      lane_ones = (LM_MAX_DW'(1) << lw) - LM_MAX_DW'(1);
      for (int unsigned i = 0; i < LM_MAX_STB; i++) begin
         if ((i < stb_n) && strb[i]) begin
            mask = mask | (lane_ones << (i * lw));
         end
      end
      return (old_w & ~mask) | (new_w & mask);
   endfunction

endpackage

// File: rtl/stk_ram_rd_pipe.sv
// Read-return pipeline: delays an accepted read by RD_LAT cycles.
//  clk, rst    : clock, synchronous active-high flush
//  in_vld_i    : read accepted this cycle
//  in_dat_i    : word snapshot taken at acceptance
//  out_vld_o   : one-cycle ack, RD_LAT cycles after acceptance
//  out_dat_o   : delivered word, holds last value while out_vld_o=0, 0 after reset
module stk_ram_rd_pipe #(
   parameter int unsigned DW     = 32,
   parameter int unsigned RD_LAT = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_vld_i,
   input  logic [DW-1:0] in_dat_i,
   output logic          out_vld_o,
   output logic [DW-1:0] out_dat_o
);

   // Clamped stage count keeps array bounds legal even for a rejected RD_LAT.
   localparam int unsigned NST = (RD_LAT < 1) ? 1 : ((RD_LAT > 3) ? 3 : RD_LAT);

   logic          vld_q [NST];
   logic [DW-1:0] dat_q [NST];

   // Data only moves with a valid token, so the last stage holds the last delivered word.
   always_ff @(posedge clk) begin : p_pipe
      if (rst) begin
         for (int unsigned k = 0; k < NST; k++) begin
            vld_q[k] <= 1'b0;
            dat_q[k] <= '0;
         end
      end else begin
         vld_q[0] <= in_vld_i;
         if (in_vld_i) begin
            dat_q[0] <= in_dat_i;
         end
         for (int unsigned k = 1; k < NST; k++) begin
            vld_q[k] <= vld_q[k-1];
            if (vld_q[k-1]) begin
               dat_q[k] <= dat_q[k-1];
            end
         end
      end
   end

   assign out_vld_o = vld_q[NST-1];
   assign out_dat_o = dat_q[NST-1];

endmodule

// File: rtl/stk_ram_slave.sv
// Stack storage responder on the StkRamIf Slave side: one read and one write
// port per cycle, zero-fill of the whole array after every reset.
//  clk, rst : clock, synchronous active-high reset
//  rd_vld   : read request           rd_adr : read address
//  rd_dat   : read data (with ack)   rd_ack : one pulse per accepted read
//  rd_rdy   : read port ready
//  wr_vld   : per-lane write strobe  wr_adr : write address
//  wr_dat   : write data             wr_rdy : write port ready
module stk_ram_slave
   import stk_ram_pkg::*;
#(
   parameter int unsigned AW     = 5,
   parameter int unsigned DW     = 32,
   parameter int unsigned STB_N  = 1,
   parameter int unsigned RD_LAT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rd_vld,
   input  logic [AW-1:0]    rd_adr,
   output logic [DW-1:0]    rd_dat,
   output logic             rd_ack,
   output logic             rd_rdy,
   input  logic [STB_N-1:0] wr_vld,
   input  logic [AW-1:0]    wr_adr,
   input  logic [DW-1:0]    wr_dat,
   output logic             wr_rdy
);

   localparam int unsigned DEPTH = 2 ** AW;
   localparam int unsigned LW    = DW / STB_N;

   // Parameter legality checks at elaboration.
   if ((DW % STB_N) != 0) begin : g_bad_lanes
      $error("stk_ram_slave: DW (%0d) must be a multiple of STB_N (%0d)", DW, STB_N);
   end
   if ((RD_LAT < 1) || (RD_LAT > 3)) begin : g_bad_lat
      $error("stk_ram_slave: RD_LAT (%0d) must be 1..3", RD_LAT);
   end
   if ((DW > LM_MAX_DW) || (STB_N > LM_MAX_STB)) begin : g_bad_size
      $error("stk_ram_slave: DW/STB_N exceed lane_merge limits");
   end

   stk_ram_st_e   state_q;
   logic [AW-1:0] clr_cnt_q;
   logic          rdy_q;

   logic [DW-1:0]    mem [DEPTH];
   logic             clr_we_c;
   logic [STB_N-1:0] wr_en_c;
   logic             rd_acc_c;
   logic [DW-1:0]    rd_word_d;

   // FSM: walk the clear counter over every word, then serve requests until reset.
   always_ff @(posedge clk) begin : p_fsm
      if (rst) begin
         state_q   <= CLEAR;
         clr_cnt_q <= '0;
         rdy_q     <= 1'b0;
      end else begin
         case (state_q)
            CLEAR: begin
               clr_cnt_q <= clr_cnt_q + AW'(1);
               if (clr_cnt_q == AW'(DEPTH - 1)) begin
                  state_q <= RUN;
                  rdy_q   <= 1'b1;
               end
            end
            RUN: begin
               state_q <= RUN;
               rdy_q   <= 1'b1;
            end
            default: begin
               state_q   <= CLEAR;
               clr_cnt_q <= '0;
               rdy_q     <= 1'b0;
            end
         endcase
      end
   end

   assign rd_rdy = rdy_q;
   assign wr_rdy = rdy_q;

   assign clr_we_c = (state_q == CLEAR) && !rst;
   assign wr_en_c  = wr_vld & {STB_N{rdy_q && !rst}};
   assign rd_acc_c = rd_vld && rdy_q;

   // Storage: clear writes own the array while clearing, strobed lane writes afterwards.
   always_ff @(posedge clk) begin : p_mem
      if (clr_we_c) begin
         mem[clr_cnt_q] <= '0;
      end else begin
         for (int unsigned i = 0; i < STB_N; i++) begin
            if (wr_en_c[i]) begin
               mem[wr_adr][i*LW +: LW] <= wr_dat[i*LW +: LW];
            end
         end
      end
   end

   // Read snapshot with write-first bypass so a same-address write is visible per lane.
   always_comb begin : p_rd_word
      rd_word_d = mem[rd_adr];
      if (rd_adr == wr_adr) begin
         rd_word_d = DW'(lane_merge(LM_MAX_DW'(mem[rd_adr]), LM_MAX_DW'(wr_dat),
                                    LM_MAX_STB'(wr_en_c), STB_N, LW));
      end
   end

   stk_ram_rd_pipe #(
      .DW     (DW),
      .RD_LAT (RD_LAT)
   ) u_rd_pipe (
      .clk       (clk),
      .rst       (rst),
      .in_vld_i  (rd_acc_c),
      .in_dat_i  (rd_word_d),
      .out_vld_o (rd_ack),
      .out_dat_o (rd_dat)
   );

endmodule
